// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state type for the instruction memory loader
package imem_loader_pkg;

    localparam int MIPS_PC_WIDTH    = 32;
    localparam int MIPS_INSTR_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } imem_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - assembles little-endian bytes into 32-bit words
module imem_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  lane;
    logic [31:0] pack;
    logic [31:0] merged;

    // pack only ever holds lanes below the current one, so upper lanes of a short final word are zero
    always_comb begin
        merged = pack;
        merged[{lane, 3'b000} +: 8] = byte_data;
    end

    assign word_valid = byte_valid && ((lane == 2'd3) || byte_last);
    assign word_data  = merged;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane <= 2'd0;
            pack <= 32'h0;
        end else if (byte_valid) begin
            if (word_valid) begin
                lane <= 2'd0;
                pack <= 32'h0;
            end else begin
                lane <= lane + 2'd1;
                pack <= merged;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-streamed program loader and instruction memory responder
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int PC_WIDTH    = MIPS_PC_WIDTH,
    parameter int INSTR_WIDTH = MIPS_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [7:0]             load_byte,
    input  logic                   load_last,
    output logic                   load_done,
    output logic                   load_err,
    output logic [$clog2(DEPTH):0] word_count,
    output logic                   core_hold,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   pc_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    imem_state_t            state;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic        xfer;
    logic        full;
    logic        pack_valid;
    logic        word_valid;
    logic [31:0] word_data;

    // load_start wins over a coincident byte: the restarted load begins empty
    assign xfer       = (state == LOAD) && load_valid && !load_start;
    assign full       = (word_count == FULL_COUNT);
    assign pack_valid = xfer && !full;

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_start),
        .byte_valid (pack_valid),
        .byte_data  (load_byte),
        .byte_last  (load_last),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // memory is never cleared; stale contents are hidden by the read gating below
    always_ff @(posedge clk) begin
        if (word_valid) begin
            mem[word_count[AW-1:0]] <= word_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            core_hold  <= 1'b1;
        end else if (load_start) begin
            state      <= LOAD;
            load_ready <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            core_hold  <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        if (full) begin
                            load_err <= 1'b1;
                        end
                        if (word_valid) begin
                            word_count <= word_count + 1'b1;
                        end
                        if (load_last) begin
                            state      <= DONE;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                            core_hold  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic [AW-1:0] index;
    logic          in_range;
    logic          hit;

    always_comb begin
        index    = pc[AW+1:2];
        in_range = (pc[PC_WIDTH-1:AW+2] == '0);
        hit      = (pc[1:0] == 2'b00) && in_range && ({1'b0, index} < word_count);
        instr    = INSTR_WIDTH'(NOP_INSTR);
        pc_fault = 1'b0;
        // a held core is not faulted; only a running core can issue a bad pc
        if (state == DONE) begin
            if (hit) begin
                instr = mem[index];
            end else begin
                pc_fault = 1'b1;
            end
        end
    end

endmodule
